// File: rtl/wb_interconnect_nslave.sv
`default_nettype none
// ============================================================================
// Module      : wb_interconnect_nslave
// Description : Wishbone classic single-master to N-slave interconnect.
//               The upper address bits select a slave window. The request is
//               registered and fanned out to all slaves, and only the selected
//               slave sees cyc/stb/we. A timeout and unmapped-address decode
//               end hung or invalid accesses with an error, and an error
//               counter plus the last error address are kept for software.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               wb_*               - master side (adr/dat in, dat/ack/err out)
//               s_*                - flattened slave side, slot i at [i*W +: W]
//               err_count, err_adr - saturating error count, last error address
// Revision    : 1.0 - initial release
// ============================================================================
module wb_interconnect_nslave #(
    parameter int NUM_SLAVES     = 4,
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int WIN_BITS       = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = {DATA_WIDTH{1'b1}}
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            wb_adr_i,
    input  logic [DATA_WIDTH-1:0]            wb_dat_i,
    output logic [DATA_WIDTH-1:0]            wb_dat_o,
    input  logic                             wb_cyc_i,
    input  logic                             wb_stb_i,
    input  logic                             wb_we_i,
    output logic                             wb_ack_o,
    output logic                             wb_err_o,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_adr_o,
    output logic [NUM_SLAVES*DATA_WIDTH-1:0] s_dat_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_dat_i,
    output logic [NUM_SLAVES-1:0]            s_cyc_o,
    output logic [NUM_SLAVES-1:0]            s_stb_o,
    output logic [NUM_SLAVES-1:0]            s_we_o,
    input  logic [NUM_SLAVES-1:0]            s_ack_i,
    output logic [7:0]                       err_count,
    output logic [ADDR_WIDTH-1:0]            err_adr
);

    localparam int IDX_W = ADDR_WIDTH - WIN_BITS;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // One extra bit so NUM_SLAVES == 2**IDX_W is representable.
    localparam logic [IDX_W:0]   c_num_slaves = (IDX_W + 1)'(NUM_SLAVES);
    localparam logic [CNT_W-1:0] c_cnt_last   = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_adr;
    logic [DATA_WIDTH-1:0]   r_dat;
    logic                    r_we;
    logic [IDX_W-1:0]        r_sel;
    logic [CNT_W-1:0]        r_cnt;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;
    logic [7:0]              r_err_count;
    logic [ADDR_WIDTH-1:0]   r_err_adr;

    logic [IDX_W-1:0]        w_idx;
    logic                    w_mapped;
    logic                    w_active;
    logic [NUM_SLAVES-1:0]   w_hit;
    logic [NUM_SLAVES-1:0]   w_ack_hit;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] w_dat_hit;
    logic                    w_sel_ack;
    logic [DATA_WIDTH-1:0]   w_sel_dat;
    logic                    w_req_ok;
    logic                    w_req_bad;
    logic                    w_done_ack;
    logic                    w_done_to;

    assign w_idx    = wb_adr_i[ADDR_WIDTH-1:WIN_BITS];
    assign w_mapped = ({1'b0, w_idx} < c_num_slaves);
    assign w_active = (r_state == S_ACTIVE);

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slave
        localparam logic [IDX_W-1:0] c_idx = IDX_W'(i);
        assign w_hit[i]     = (r_sel == c_idx);
        assign s_cyc_o[i]   = w_active & w_hit[i];
        assign s_stb_o[i]   = w_active & w_hit[i];
        assign s_we_o[i]    = w_active & w_hit[i] & r_we;
        assign s_adr_o[i*ADDR_WIDTH +: ADDR_WIDTH] = r_adr;
        assign s_dat_o[i*DATA_WIDTH +: DATA_WIDTH] = r_dat;
        // Acks and data from non-selected slaves are masked out here.
        assign w_ack_hit[i] = s_ack_i[i] & w_hit[i];
        assign w_dat_hit[i*DATA_WIDTH +: DATA_WIDTH] =
            s_dat_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_hit[i]}};
    end

    assign w_sel_ack = |w_ack_hit;

    always_comb begin
        w_sel_dat = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_sel_dat = w_sel_dat | w_dat_hit[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Master abort has priority over a same-cycle ack; an ack has priority
    // over a same-cycle timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_req_ok    = 1'b0;
        w_req_bad   = 1'b0;
        w_done_ack  = 1'b0;
        w_done_to   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    if (w_mapped) begin
                        w_state_nxt = S_ACTIVE;
                        w_req_ok    = 1'b1;
                    end else begin
                        w_state_nxt = S_RESP;
                        w_req_bad   = 1'b1;
                    end
                end
            end
            S_ACTIVE: begin
                if (!wb_cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else if (w_sel_ack) begin
                    w_state_nxt = S_RESP;
                    w_done_ack  = 1'b1;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = S_RESP;
                    w_done_to   = 1'b1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_adr       <= '0;
            r_dat       <= '0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_err_count <= '0;
            r_err_adr   <= '0;
        end else begin
            if (w_req_ok || w_req_bad) begin
                r_adr <= wb_adr_i;
                r_dat <= wb_dat_i;
                r_we  <= wb_we_i;
                r_sel <= w_idx;
            end
            if (w_req_ok) begin
                r_cnt <= '0;
            end else if (w_active) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_done_ack) begin
                r_rdata <= w_sel_dat;
            end else if (w_done_to || w_req_bad) begin
                r_rdata <= ERR_DATA;
            end
            if (w_done_ack || w_done_to || w_req_bad) begin
                r_err <= w_done_to | w_req_bad;
            end
            // Statistics update on the edge that enters RESP, so they are
            // already valid while the error ack is on the bus.
            if (w_done_to || w_req_bad) begin
                if (r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                end
                r_err_adr <= w_req_bad ? wb_adr_i : r_adr;
            end
        end
    end

    assign wb_ack_o  = (r_state == S_RESP);
    assign wb_err_o  = (r_state == S_RESP) & r_err;
    assign wb_dat_o  = r_rdata;
    assign err_count = r_err_count;
    assign err_adr   = r_err_adr;

endmodule
`default_nettype wire

// File: tb/tb_wb_interconnect_nslave.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_interconnect_nslave
// Description : Directed bench for wb_interconnect_nslave (4 slaves, 8-bit
//               address/data, 16-byte windows, timeout of 8 cycles).
//               Stimulus tasks describe whole transactions and publish the
//               expected bus outputs for every cycle. One compare process
//               checks them on the falling edge, and a few literal checks pin
//               the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_interconnect_nslave;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  wb_adr_i, wb_dat_i, wb_dat_o;
    logic        wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o, wb_err_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_cyc_o, s_stb_o, s_we_o, s_ack_i;
    logic [7:0]  err_count, err_adr;

    wb_interconnect_nslave #(
        .NUM_SLAVES(4), .ADDR_WIDTH(8), .DATA_WIDTH(8), .WIN_BITS(4),
        .TIMEOUT_CYCLES(TO), .ERR_DATA(8'hFF)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_ack_i(s_ack_i), .err_count(err_count), .err_adr(err_adr)
    );

    always #5 clk = ~clk;

    // Expected outputs for the current cycle.
    logic       cmp_en = 1'b0;
    logic [3:0] exp_stb = '0;
    logic       exp_we = 1'b0, exp_ack = 1'b0, exp_err = 1'b0, exp_fan = 1'b0;
    logic [7:0] exp_dat = '0, exp_cnt = '0, exp_eadr = '0, exp_sadr = '0, exp_sdat = '0;

    int n_checks = 0;
    int n_pass   = 0;
    int stb1_cycles = 0;
    int ack_pulses  = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    // Per-cycle compare against the published expectations.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("s_cyc", {28'd0, s_cyc_o}, {28'd0, exp_stb});
                chk("s_stb", {28'd0, s_stb_o}, {28'd0, exp_stb});
                chk("s_we", {28'd0, s_we_o}, {28'd0, exp_stb & {4{exp_we}}});
                chk("wb_ack", {31'd0, wb_ack_o}, {31'd0, exp_ack});
                chk("wb_err", {31'd0, wb_err_o}, {31'd0, exp_err});
                chk("wb_dat", {24'd0, wb_dat_o}, {24'd0, exp_dat});
                chk("err_count", {24'd0, err_count}, {24'd0, exp_cnt});
                chk("err_adr", {24'd0, err_adr}, {24'd0, exp_eadr});
                if (exp_fan) begin
                    for (int i = 0; i < 4; i++) begin
                        chk("s_adr", {24'd0, s_adr_o[i*8 +: 8]}, {24'd0, exp_sadr});
                        chk("s_dat", {24'd0, s_dat_o[i*8 +: 8]}, {24'd0, exp_sdat});
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (s_stb_o[1] === 1'b1) stb1_cycles++;
        if (wb_ack_o === 1'b1) ack_pulses++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_idle();
        exp_stb = '0; exp_we = 1'b0; exp_ack = 1'b0; exp_err = 1'b0; exp_fan = 1'b0;
    endtask

    task automatic count_error(input logic [7:0] adr);
        exp_cnt  = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
        exp_eadr = adr;
    endtask

    task automatic present(input logic [7:0] adr, input logic [7:0] wdat, input logic we);
        wb_adr_i = adr; wb_dat_i = wdat; wb_we_i = we; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    endtask

    task automatic release_bus();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; s_ack_i = '0;
        exp_idle();
    endtask

    // Mapped transaction. The selected slave acks after wait_n wait states
    // (wait_n < 0: never). Non-selected slaves see the noise ack pattern.
    task automatic txn(input logic [7:0] adr, input logic [7:0] wdat, input logic we,
                       input int wait_n, input logic [7:0] rdat, input logic [3:0] noise);
        int sel; logic [3:0] oh; bit timed_out; int n_active;
        sel = int'(adr[7:4]);
        oh = 4'b0001 << sel;
        timed_out = (wait_n < 0) || (wait_n + 1 > TO);
        n_active  = timed_out ? TO : wait_n + 1;
        present(adr, wdat, we);
        s_ack_i = noise & ~oh;
        s_dat_i = 32'h6699_CC33;
        for (int k = 1; k <= n_active; k++) begin
            step();
            exp_stb = oh; exp_we = we; exp_fan = 1'b1; exp_sadr = adr; exp_sdat = wdat;
            exp_ack = 1'b0; exp_err = 1'b0;
            s_ack_i = noise & ~oh;
            if (!timed_out && k == n_active) begin
                s_ack_i[sel] = 1'b1;
                s_dat_i[sel*8 +: 8] = rdat;
            end
        end
        step();
        s_ack_i = noise & ~oh;
        exp_stb = '0; exp_we = 1'b0; exp_fan = 1'b0; exp_ack = 1'b1; exp_err = timed_out;
        exp_dat = timed_out ? 8'hFF : rdat;
        if (timed_out) count_error(adr);
        step();
        release_bus();
    endtask

    task automatic unmapped(input logic [7:0] adr);
        present(adr, 8'h00, 1'b0);
        step();
        exp_idle(); exp_ack = 1'b1; exp_err = 1'b1; exp_dat = 8'hFF;
        count_error(adr);
        step();
        release_bus();
    endtask

    initial begin
        int acks_before;
        rst = 1'b1; wb_adr_i = '0; wb_dat_i = '0; wb_we_i = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; s_ack_i = '0; s_dat_i = '0;

        // Reset: every output zero, slave fan-out included.
        step();
        exp_idle(); exp_fan = 1'b1; exp_sadr = '0; exp_sdat = '0;
        cmp_en = 1'b1;
        step();
        rst = 1'b0;
        step();
        exp_fan = 1'b0;

        // 1: zero-wait write to slave 0; the write still captures slave data.
        txn(8'h03, 8'h05, 1'b1, 0, 8'h3C, 4'b0000);
        chk("t1_dat_lit", {24'd0, wb_dat_o}, 32'h3C);

        // 2: slave 2, three wait states, other slaves acking throughout.
        acks_before = ack_pulses;
        txn(8'h21, 8'h00, 1'b0, 3, 8'hA5, 4'b1011);
        chk("t2_dat_lit", {24'd0, wb_dat_o}, 32'hA5);
        chk("t2_one_ack_lit", ack_pulses - acks_before, 1);

        // 3: unmapped address.
        unmapped(8'h40);
        chk("t3_cnt_lit", {24'd0, err_count}, 32'd1);
        chk("t3_adr_lit", {24'd0, err_adr}, 32'h40);

        // 4: slave 1 never acks.
        stb1_cycles = 0;
        txn(8'h12, 8'h77, 1'b0, -1, 8'h00, 4'b0000);
        chk("t4_active_lit", stb1_cycles, 8);
        chk("t4_cnt_lit", {24'd0, err_count}, 32'd2);
        chk("t4_adr_lit", {24'd0, err_adr}, 32'h12);

        // 5: ack in the last ACTIVE cycle wins over the timeout.
        txn(8'h35, 8'h00, 1'b0, TO - 1, 8'h7E, 4'b0000);
        chk("t5_dat_lit", {24'd0, wb_dat_o}, 32'h7E);
        chk("t5_cnt_lit", {24'd0, err_count}, 32'd2);

        // 6a: master abort mid-ACTIVE.
        acks_before = ack_pulses;
        present(8'h2A, 8'h11, 1'b1);
        step();
        exp_stb = 4'b0100; exp_we = 1'b1; exp_fan = 1'b1; exp_sadr = 8'h2A; exp_sdat = 8'h11;
        step();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        step();
        exp_idle();
        step();
        step();
        chk("t6_no_ack_lit", ack_pulses - acks_before, 0);

        // 6b: reset mid-ACTIVE clears everything, including statistics.
        present(8'h14, 8'h22, 1'b0);
        step();
        exp_stb = 4'b0010; exp_fan = 1'b1; exp_sadr = 8'h14; exp_sdat = 8'h22;
        step();
        rst = 1'b1;
        step();
        exp_idle(); exp_fan = 1'b1; exp_sadr = '0; exp_sdat = '0;
        exp_dat = '0; exp_cnt = '0; exp_eadr = '0;
        rst = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        step();
        exp_fan = 1'b0;
        chk("t6_cnt_lit", {24'd0, err_count}, 32'd0);

        // Normal operation after reset.
        txn(8'h0F, 8'h00, 1'b0, 1, 8'h5D, 4'b1110);

        // Saturation: 300 unmapped errors.
        for (int i = 0; i < 300; i++) begin
            unmapped(8'h40 + 8'(16 * (i % 12)) + 8'(i % 16));
        end
        chk("sat_cnt_lit", {24'd0, err_count}, 32'hFF);

        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
